// File: rtl/muldiv_ctrl.sv
// RV32M execute-stage sequencer: iterative shift-add multiply / restoring divide with sign fix-up.
// Optional `MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply-by-zero finish after one BUSY cycle.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start_E,
    input  logic [2:0]       MdOp_E,
    input  logic [WIDTH-1:0] SrcA_E,
    input  logic [WIDTH-1:0] SrcB_E,
    input  logic             Flush_E,
    output logic             Stall_MD,
    output logic             Done_MD,
    output logic [WIDTH-1:0] Result_MD
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_ovf;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
`ifdef MULDIV_EARLY_OUT_EN
    logic               r_mzero;
    logic               w_mzero;
    logic               w_early;
`endif

    logic               w_sa;
    logic               w_sb;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_dz;
    logic               w_ovf;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_result;

    // Operand decode: signedness per funct3, magnitudes and special-case detection
    always_comb begin
        w_sa    = (MdOp_E == 3'b001) || (MdOp_E == 3'b010) || (MdOp_E[2] && !MdOp_E[0]);
        w_sb    = (MdOp_E == 3'b001) || (MdOp_E[2] && !MdOp_E[0]);
        w_neg_a = w_sa && SrcA_E[WIDTH-1];
        w_neg_b = w_sb && SrcB_E[WIDTH-1];
        w_mag_a = w_neg_a ? -SrcA_E : SrcA_E;
        w_mag_b = w_neg_b ? -SrcB_E : SrcB_E;
        w_dz    = MdOp_E[2] && (SrcB_E == ZERO);
        w_ovf   = MdOp_E[2] && !MdOp_E[0] && (SrcA_E == MOST_NEG) && (SrcB_E == ALL_ONES);
`ifdef MULDIV_EARLY_OUT_EN
        w_mzero = !MdOp_E[2] && ((SrcA_E == ZERO) || (SrcB_E == ZERO));
        w_early = w_dz || w_ovf || w_mzero;
`endif
    end

    // One iteration: multiply adds into the upper half then shifts right; divide is a restoring step
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_rem_ge  = (w_rem_sh >= {1'b0, r_opnd});
        w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
        if (r_op[2]) begin
            w_acc_nxt = {(w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_rem_ge};
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Final result from the last iteration; high product half negated as ~hi + (lo == 0)
    always_comb begin
        w_hi_fix   = r_neg_q ? (~w_acc_nxt[2*WIDTH-1:WIDTH]
                                + {{(WIDTH-1){1'b0}}, (w_acc_nxt[WIDTH-1:0] == ZERO)})
                             : w_acc_nxt[2*WIDTH-1:WIDTH];
        w_quot_fix = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
        w_rem_fix  = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
        case (r_op)
            3'b000:                 w_result = w_acc_nxt[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_hi_fix;
            3'b100, 3'b101: begin
                if (r_dz) begin
                    w_result = ALL_ONES;
                end else if (r_ovf) begin
                    w_result = r_a_raw;
                end else begin
                    w_result = w_quot_fix;
                end
            end
            3'b110, 3'b111: begin
                if (r_dz) begin
                    w_result = r_a_raw;
                end else if (r_ovf) begin
                    w_result = ZERO;
                end else begin
                    w_result = w_rem_fix;
                end
            end
            default:                w_result = ZERO;
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (r_mzero) begin
            w_result = ZERO;
        end else begin
            w_result = w_result;
        end
`endif
    end

    // Sequencer FSM with registered Done/Result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_op     <= 3'b000;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_opnd   <= ZERO;
            r_a_raw  <= ZERO;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= ZERO;
`ifdef MULDIV_EARLY_OUT_EN
            r_mzero  <= 1'b0;
`endif
        end else if (Flush_E) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start_E) begin
                        r_state <= S_BUSY;
                        r_op    <= MdOp_E;
                        r_a_raw <= SrcA_E;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_dz    <= w_dz;
                        r_ovf   <= w_ovf;
                        if (MdOp_E[2]) begin
                            r_acc  <= {ZERO, w_mag_a};
                            r_opnd <= w_mag_b;
                        end else begin
                            r_acc  <= {ZERO, w_mag_b};
                            r_opnd <= w_mag_a;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        r_mzero <= w_mzero;
                        r_cnt   <= w_early ? {CW{1'b0}} : CW'(WIDTH-1);
`else
                        r_cnt   <= CW'(WIDTH-1);
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_result;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the accept cycle and every BUSY cycle, dropped by a flush
    always_comb begin
        Stall_MD = 1'b0;
        if (Flush_E) begin
            Stall_MD = 1'b0;
        end else if (r_state == S_BUSY) begin
            Stall_MD = 1'b1;
        end else if (r_state == S_IDLE) begin
            Stall_MD = Start_E;
        end else begin
            Stall_MD = 1'b0;
        end
    end

    assign Done_MD   = r_done;
    assign Result_MD = r_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: results, latency, stall profile, flush and async reset.
module tb_muldiv_ctrl;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SP_LAT = 2;
`else
    localparam int SP_LAT = W + 1;
`endif
    localparam int FULL_LAT = W + 1;

    logic         clk;
    logic         rst_n;
    logic         Start_E;
    logic [2:0]   MdOp_E;
    logic [W-1:0] SrcA_E;
    logic [W-1:0] SrcB_E;
    logic         Flush_E;
    logic         Stall_MD;
    logic         Done_MD;
    logic [W-1:0] Result_MD;

    int total_cnt;
    int bad_cnt;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start_E   (Start_E),
        .MdOp_E    (MdOp_E),
        .SrcA_E    (SrcA_E),
        .SrcB_E    (SrcB_E),
        .Flush_E   (Flush_E),
        .Stall_MD  (Stall_MD),
        .Done_MD   (Done_MD),
        .Result_MD (Result_MD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; holds Start_E until Done_MD is seen
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int  n;
        int  stalls;
        bit  seen;
        Start_E = 1'b1;
        MdOp_E  = op;
        SrcA_E  = a;
        SrcB_E  = b;
        #1;
        check_eq($sformatf("%s.acc_stall", tag), 32'(Stall_MD), 32'd1);
        stalls = 1;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (Done_MD) seen = 1'b1;
            else if (Stall_MD) stalls++;
        end
        check_eq($sformatf("%s.latency", tag), 32'(n), 32'(exp_lat));
        check_eq($sformatf("%s.stall_cycles", tag), 32'(stalls), 32'(exp_lat));
        check_eq($sformatf("%s.done_stall", tag), 32'(Stall_MD), 32'd0);
        check_eq($sformatf("%s.result", tag), Result_MD, exp_res);
        Start_E = 1'b0;
        @(negedge clk);
        check_eq($sformatf("%s.done_drop", tag), 32'(Done_MD), 32'd0);
        check_eq($sformatf("%s.idle_stall", tag), 32'(Stall_MD), 32'd0);
        check_eq($sformatf("%s.hold", tag), Result_MD, exp_res);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n   = 1'b0;
        Start_E = 1'b0;
        MdOp_E  = 3'b000;
        SrcA_E  = 32'd0;
        SrcB_E  = 32'd0;
        Flush_E = 1'b0;
        #2;
        check_eq("rst.stall", 32'(Stall_MD), 32'd0);
        check_eq("rst.done", 32'(Done_MD), 32'd0);
        check_eq("rst.result", Result_MD, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul",      3'b000, 32'd7,          32'd6,          32'd42,         FULL_LAT);
        run_op("mul_neg",  3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  FULL_LAT);
        run_op("mulh",     3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  FULL_LAT);
        run_op("mulh_neg", 3'b001, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  FULL_LAT);
        run_op("mulhsu",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  FULL_LAT);
        run_op("mulhu",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  FULL_LAT);
        run_op("div",      3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  FULL_LAT);
        run_op("rem",      3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  FULL_LAT);
        run_op("divu",     3'b101, 32'd100,        32'd7,          32'd14,         FULL_LAT);
        run_op("remu",     3'b111, 32'd100,        32'd7,          32'd2,          FULL_LAT);
        run_op("div_dz",   3'b100, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  SP_LAT);
        run_op("rem_dz",   3'b110, 32'h1234_5678,  32'd0,          32'h1234_5678,  SP_LAT);
        run_op("div_dzn",  3'b100, 32'h8000_0001,  32'd0,          32'hFFFF_FFFF,  SP_LAT);
        run_op("rem_dzn",  3'b110, 32'h8000_0001,  32'd0,          32'h8000_0001,  SP_LAT);
        run_op("divu_dz",  3'b101, 32'hCAFE_0001,  32'd0,          32'hFFFF_FFFF,  SP_LAT);
        run_op("div_ovf",  3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SP_LAT);
        run_op("rem_ovf",  3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SP_LAT);
        run_op("mul_zero", 3'b000, 32'd0,          32'd5,          32'd0,          SP_LAT);
        run_op("mulh_z",   3'b001, 32'hFFFF_FFFD,  32'd0,          32'd0,          SP_LAT);

        // Flush a DIVU ten cycles after accept, then start a MUL on the next cycle
        Start_E = 1'b1;
        MdOp_E  = 3'b101;
        SrcA_E  = 32'd100;
        SrcB_E  = 32'd7;
        #1;
        check_eq("flush.acc_stall", 32'(Stall_MD), 32'd1);
        repeat (10) @(negedge clk);
        check_eq("flush.busy_stall", 32'(Stall_MD), 32'd1);
        Flush_E = 1'b1;
        #1;
        check_eq("flush.stall", 32'(Stall_MD), 32'd0);
        check_eq("flush.done", 32'(Done_MD), 32'd0);
        @(negedge clk);
        Flush_E = 1'b0;
        check_eq("flush.no_done", 32'(Done_MD), 32'd0);
        run_op("after_flush", 3'b000, 32'd7, 32'd6, 32'd42, FULL_LAT);

        // Asynchronous reset mid-multiply, away from any clock edge
        run_op("pre_rst", 3'b011, 32'd3, 32'd5, 32'd0, FULL_LAT);
        run_op("pre_rst2", 3'b000, 32'd3, 32'd5, 32'd15, FULL_LAT);
        Start_E = 1'b1;
        MdOp_E  = 3'b000;
        SrcA_E  = 32'd9;
        SrcB_E  = 32'd9;
        repeat (5) @(negedge clk);
        #2;
        rst_n   = 1'b0;
        Start_E = 1'b0;
        #1;
        check_eq("arst.stall", 32'(Stall_MD), 32'd0);
        check_eq("arst.done", 32'(Done_MD), 32'd0);
        check_eq("arst.result", Result_MD, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst.idle_stall", 32'(Stall_MD), 32'd0);
        run_op("restart", 3'b000, 32'd9, 32'd9, 32'd81, FULL_LAT);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
